if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter NOP_WORD, default 32'h00000000, instruction word inserted as a bubble.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..3, number of consecutive bubble cycles per flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PC_plus4_in  input  32  PC+4 from the fetch stage.
REQ-006 SHALL have port Instr_in  input  32  instruction word from instruction memory.
REQ-007 SHALL have port IFIDWrite  input  1  1 = capture, 0 = stall/hold (from hazard unit).
REQ-008 SHALL have port IF_Flush  input  1  1 = squash the fetched instruction (branch/jump taken).
REQ-009 SHALL have port PC_plus4_out  output  32  registered PC+4 to decode.
REQ-010 SHALL have port Instr_out  output  32  registered instruction to decode.
REQ-011 SHALL have port Valid_out  output  1  1 = Instr_out is a real instruction, 0 = bubble.
REQ-012 SHALL have port Stall_cnt  output  16  count of stalled cycles (see Configuration).

Function
REQ-013 SHALL implement a three-state machine: RUN, HOLD, FLUSH.
REQ-014 SHALL have one-cycle latency: inputs captured at edge N appear on outputs after edge N.
REQ-015 In RUN or HOLD with IF_Flush=0, IFIDWrite=1: SHALL capture PC_plus4_in, Instr_in, set Valid_out=1, next state RUN.
REQ-016 In RUN or HOLD with IF_Flush=0, IFIDWrite=0: SHALL keep all outputs unchanged, next state HOLD.
REQ-017 With IF_Flush=1 in any state: SHALL load Instr_out=NOP_WORD, PC_plus4_out=0, Valid_out=0, load a 2-bit counter with FLUSH_CYCLES-1, next state FLUSH if counter value >0, else RUN.
REQ-018 IF_Flush SHALL take priority over IFIDWrite=0 in the same cycle.
REQ-019 In FLUSH with IF_Flush=0: SHALL hold bubble outputs, ignore IFIDWrite, decrement counter; on counter reaching 0, next state RUN.
REQ-020 IF_Flush re-asserted while in FLUSH SHALL reload the counter to FLUSH_CYCLES-1.
REQ-021 With FLUSH_CYCLES=N, exactly N consecutive bubble cycles SHALL appear on outputs after one single-cycle IF_Flush pulse.
REQ-022 A stalled cycle SHALL be any edge where state is RUN or HOLD, IF_Flush=0, IFIDWrite=0.

Reset
REQ-023 RST=0 SHALL immediately force PC_plus4_out=0, Instr_out=NOP_WORD, Valid_out=0, Stall_cnt=0, counter=0, state RUN, independent of clk.
REQ-024 Reset asserted mid-FLUSH or mid-HOLD SHALL abandon that state; first edge after RST=1 behaves as RUN.

Configuration
REQ-025 Macro IF_ID_STALL_CNT_EN defined: Stall_cnt SHALL increment by 1 on each stalled cycle, saturating at 16'hFFFF.
REQ-026 Macro IF_ID_STALL_CNT_EN undefined: counter logic SHALL be absent and Stall_cnt SHALL be constant 0.

Structure
REQ-027 Shared package mips_pipe_pkg SHALL hold NOP_WORD default, the 32-bit word width constant and the RUN/HOLD/FLUSH state encoding.
REQ-028 The saturating stall counter SHALL be a sub-module named sat_counter, instantiated only under IF_ID_STALL_CNT_EN.

Verification
REQ-029 Reset: RST=0 with inputs 32'h00400004/32'h8C220000 -> outputs 0/NOP_WORD/0 asynchronously, unchanged by clk while RST=0.
REQ-030 Capture: IFIDWrite=1, PC_plus4_in=32'h00400008, Instr_in=32'h01094020 -> next edge outputs those values, Valid_out=1.
REQ-031 Stall: IFIDWrite=0 for 3 cycles with changing inputs -> outputs hold prior values; Stall_cnt=3 (macro on) or 0 (macro off).
REQ-032 Flush vs stall: IF_Flush=1 and IFIDWrite=0 same cycle -> Instr_out=NOP_WORD, Valid_out=0, Stall_cnt not incremented.
REQ-033 Multi-bubble: FLUSH_CYCLES=3, one IF_Flush pulse with IFIDWrite=1 -> exactly 3 bubble cycles, then capture resumes on the 4th edge.
REQ-034 Reset mid-flush: FLUSH_CYCLES=3, RST=0 after first bubble, released -> first edge captures inputs with Valid_out=1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants and types for the MIPS pipeline registers.
//   WORD_W        : datapath word width (instruction and PC words)
//   STALL_W       : width of the stall-cycle counter
//   FCNT_W        : width of the flush bubble counter
//   NOP_WORD_DEF  : default instruction word used as a pipeline bubble
//   if_id_state_e : IF/ID register control states (RUN, HOLD, FLUSH)
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STALL_W = 16;
    localparam int unsigned FCNT_W  = 2;

    localparam logic [WORD_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FLUSH = 2'b10
    } if_id_state_e;

endpackage : mips_pipe_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments on inc and sticks at its all-ones value.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with stall (hold), flush (bubble insertion) and an
// optional stall-cycle counter.
// Parameters:
//   NOP_WORD     : instruction word presented while a bubble is in ID
//   FLUSH_CYCLES : bubble cycles produced by one flush pulse (1..3)
// Ports:
//   clk          : clock, rising edge
//   RST          : asynchronous active-low reset
//   PC_plus4_in  : PC+4 from fetch
//   Instr_in     : fetched instruction word
//   IFIDWrite    : 1 = capture, 0 = hold (hazard unit stall)
//   IF_Flush     : 1 = squash the fetched instruction
//   PC_plus4_out : registered PC+4 to decode
//   Instr_out    : registered instruction to decode
//   Valid_out    : 1 = real instruction, 0 = bubble
//   Stall_cnt    : saturating count of stalled cycles
// Build option:
//   IF_ID_STALL_CNT_EN : when defined, Stall_cnt counts stalled cycles;
//                        otherwise it is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module if_id_reg
    import mips_pipe_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD     = NOP_WORD_DEF,
    parameter int unsigned       FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [WORD_W-1:0]  PC_plus4_in,
    input  logic [WORD_W-1:0]  Instr_in,
    input  logic               IFIDWrite,
    input  logic               IF_Flush,
    output logic [WORD_W-1:0]  PC_plus4_out,
    output logic [WORD_W-1:0]  Instr_out,
    output logic               Valid_out,
    output logic [STALL_W-1:0] Stall_cnt
);

    // Counter value loaded on a flush: remaining bubbles after the first.
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    if_id_state_e      state_q, state_d;
    logic [FCNT_W-1:0] cnt_q,   cnt_d;
    logic [WORD_W-1:0] pc_q,    pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;

    // Next-state and next-output logic; flush overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        if (IF_Flush) begin
            pc_d    = '0;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            cnt_d   = FLUSH_LOAD;
            state_d = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (IFIDWrite) begin
                        pc_d    = PC_plus4_in;
                        instr_d = Instr_in;
                        valid_d = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_FLUSH: begin
                    // Bubble outputs stay put; IFIDWrite is ignored here.
                    if (cnt_q <= FCNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - FCNT_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign PC_plus4_out = pc_q;
    assign Instr_out    = instr_q;
    assign Valid_out    = valid_q;

`ifdef IF_ID_STALL_CNT_EN
    // A stall is a hold request while not flushing and not draining bubbles.
    logic stall_c;
    assign stall_c = (state_q != ST_FLUSH) && !IF_Flush && !IFIDWrite;

    sat_counter #(
        .WIDTH (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (RST),
        .inc   (stall_c),
        .count (Stall_cnt)
    );
`else
    assign Stall_cnt = '0;
`endif

endmodule : if_id_reg

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg
// Self-checking bench for if_id_reg: directed reset/capture/stall/flush cases
// followed by randomized traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_if_id_reg;
    import mips_pipe_pkg::*;

    localparam int unsigned     F_CYC = 3;
    localparam logic [31:0]     NOP   = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] PC_plus4_in = '0;
    logic [31:0] Instr_in = '0;
    logic        IFIDWrite = 1'b0;
    logic        IF_Flush = 1'b0;
    logic [31:0] PC_plus4_out;
    logic [31:0] Instr_out;
    logic        Valid_out;
    logic [15:0] Stall_cnt;

    if_id_reg #(
        .NOP_WORD     (NOP),
        .FLUSH_CYCLES (F_CYC)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .PC_plus4_in  (PC_plus4_in),
        .Instr_in     (Instr_in),
        .IFIDWrite    (IFIDWrite),
        .IF_Flush     (IF_Flush),
        .PC_plus4_out (PC_plus4_out),
        .Instr_out    (Instr_out),
        .Valid_out    (Valid_out),
        .Stall_cnt    (Stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: visible register contents plus bubbles still owed.
    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    int          m_bub;
    int          m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_bub = 0; m_stall = 0;
    endtask

    task automatic model_edge();
        if (IF_Flush) begin
            m_pc = '0; m_instr = NOP; m_valid = 1'b0;
            m_bub = int'(F_CYC) - 1;
        end else if (m_bub > 0) begin
            m_bub--;
        end else if (IFIDWrite) begin
            m_pc = PC_plus4_in; m_instr = Instr_in; m_valid = 1'b1;
        end else begin
            if (m_stall < 65535) m_stall++;
        end
    endtask

    function automatic logic [31:0] exp_stall();
`ifdef IF_ID_STALL_CNT_EN
        return 32'(m_stall);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pc"},    PC_plus4_out,     m_pc);
        check({tag, ".instr"}, Instr_out,        m_instr);
        check({tag, ".valid"}, 32'(Valid_out),   32'(m_valid));
        check({tag, ".stall"}, 32'(Stall_cnt),   exp_stall());
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                         input logic wr, input logic fl);
        PC_plus4_in = pc; Instr_in = ins; IFIDWrite = wr; IF_Flush = fl;
    endtask

    // One clock: model follows the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] stall_exp3;
        model_reset();

        // Asynchronous reset before any clock edge, held through two edges.
        drive(32'h0040_0004, 32'h8C22_0000, 1'b1, 1'b0);
        #1 RST = 1'b0;
        #1 check_all("rst_async");
        repeat (2) begin
            @(posedge clk); #1;
            check_all("rst_hold");
        end
        RST = 1'b1;

        // Capture.
        drive(32'h0040_0008, 32'h0109_4020, 1'b1, 1'b0);
        step("capture");
        check("capture.valid1", 32'(Valid_out), 32'd1);

        // Three stall cycles with changing inputs.
        for (int i = 0; i < 3; i++) begin
            drive(32'h1000_0000 + 32'(i), 32'hABC0_0000 + 32'(i), 1'b0, 1'b0);
            step("stall");
        end
`ifdef IF_ID_STALL_CNT_EN
        stall_exp3 = 32'd3;
`else
        stall_exp3 = 32'd0;
`endif
        check("stall3.cnt", 32'(Stall_cnt), stall_exp3);
        check("stall3.pc",  PC_plus4_out, 32'h0040_0008);

        // Flush and stall in the same cycle: flush wins, no stall counted.
        drive(32'h0040_000C, 32'h2222_0000, 1'b0, 1'b1);
        step("flush_vs_stall");
        check("fvs.cnt", 32'(Stall_cnt), stall_exp3);
        drive(32'h0040_0010, 32'h3333_0000, 1'b1, 1'b0);
        repeat (F_CYC - 1) step("fvs_drain");

        // Multi-bubble: one pulse with write=1, exactly F_CYC bubbles.
        drive(32'h0040_0020, 32'h4444_0000, 1'b1, 1'b0);
        step("pre_flush");
        drive(32'h0040_0024, 32'h5555_0000, 1'b1, 1'b1);
        step("bubble0");
        drive(32'h0040_0028, 32'h6666_0000, 1'b1, 1'b0);
        for (int i = 1; i < int'(F_CYC); i++) begin
            step("bubble");
            check("bubble.valid0", 32'(Valid_out), 32'd0);
        end
        step("resume");
        check("resume.instr", Instr_out, 32'h6666_0000);

        // Reset mid-flush: first edge after release captures.
        drive(32'h0040_0030, 32'h7777_0000, 1'b1, 1'b1);
        step("rmf_bubble");
        drive(32'h0040_0034, 32'h8888_0000, 1'b1, 1'b0);
        RST = 1'b0;
        model_reset();
        #1 check_all("rmf_async");
        #2 RST = 1'b1;
        step("rmf_capture");
        check("rmf.valid1", 32'(Valid_out), 32'd1);

        // Reset mid-hold, then randomized traffic.
        drive(32'h0040_0040, 32'h9999_0000, 1'b0, 1'b0);
        step("pre_rmh");
        RST = 1'b0;
        model_reset();
        #1 check_all("rmh_async");
        #2 RST = 1'b1;
        drive(32'h0040_0044, 32'hAAAA_0000, 1'b1, 1'b0);
        step("rmh_capture");

        for (int i = 0; i < 400; i++) begin
            drive($urandom, $urandom, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_id_reg
